// File: rtl/a5_1_controller_pkg.sv
// Shared constants and state type for the A5/1 keystream sequencer.
// Register lengths are kept here for the X/Y/Z LFSR modules.
package a5_1_controller_pkg;

   localparam int KEY_LEN    = 64;
   localparam int FRAME_LEN  = 22;
   localparam int MIX_CYCLES = 100;
   localparam int KS_LEN     = 228;

   localparam int X_LEN = 19;
   localparam int Y_LEN = 22;
   localparam int Z_LEN = 23;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_KEY   = 3'd2,
      S_FRAME = 3'd3,
      S_MIX   = 3'd4,
      S_GEN   = 3'd5,
      S_DRAIN = 3'd6
   } state_e;

   function automatic logic [7:0] last_cnt(input int len);
      return 8'(len - 1);
   endfunction

endpackage

// File: rtl/a5_1_controller_majority.sv
// Majority clock rule: a register steps when its clocking bit
// agrees with the majority of the three clocking bits.
module a5_1_majority_clock (
   input  logic x_maj,
   input  logic y_maj,
   input  logic z_maj,
   input  logic enable,
   output logic x_trigger,
   output logic y_trigger,
   output logic z_trigger
);

   logic m;

   assign m = (x_maj & y_maj) | (x_maj & z_maj) | (y_maj & z_maj);

   assign x_trigger = enable & (x_maj == m);
   assign y_trigger = enable & (y_maj == m);
   assign z_trigger = enable & (z_maj == m);

endmodule

// File: rtl/a5_1_controller.sv
// A5/1 sequencer: clear, key load, frame load, mixing, then
// bit-serial keystream output under a valid/ready handshake.
module a5_1_controller
   import a5_1_controller_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] key,
   input  logic [21:0] frame,
   input  logic        x_maj,
   input  logic        y_maj,
   input  logic        z_maj,
   input  logic        x_out,
   input  logic        y_out,
   input  logic        z_out,
   output logic        regs_clear,
   output logic        x_trigger,
   output logic        y_trigger,
   output logic        z_trigger,
   output logic        shift_bit,
   output logic        ks_bit,
   output logic        ks_valid,
   input  logic        ks_ready,
   output logic        busy,
   output logic        done
);

   localparam logic [7:0] KEY_LAST   = last_cnt(KEY_LEN);
   localparam logic [7:0] FRAME_LAST = last_cnt(FRAME_LEN);
   localparam logic [7:0] MIX_LAST   = last_cnt(MIX_CYCLES);
   localparam logic [7:0] KS_LAST    = last_cnt(KS_LEN);

   state_e      state_q;
   logic [7:0]  cnt_q;
   logic [63:0] key_q;
   logic [21:0] frame_q;
   logic        regs_clear_q;
   logic        ks_valid_q;
   logic        ks_valid_d;
   logic        done_q;

   logic fire;
   logic loading;
   logic maj_en;
   logic mx, my, mz;

   assign fire    = !ks_valid_q || ks_ready;
   assign loading = (state_q == S_KEY) || (state_q == S_FRAME);
   assign maj_en  = (state_q == S_MIX) || ((state_q == S_GEN) && fire);

   a5_1_majority_clock u_maj (
      .x_maj     (x_maj),
      .y_maj     (y_maj),
      .z_maj     (z_maj),
      .enable    (maj_en),
      .x_trigger (mx),
      .y_trigger (my),
      .z_trigger (mz)
   );

   assign x_trigger = loading | mx;
   assign y_trigger = loading | my;
   assign z_trigger = loading | mz;

   assign shift_bit = ((state_q == S_KEY) & key_q[0])
                    | ((state_q == S_FRAME) & frame_q[0]);

   assign ks_bit     = x_out ^ y_out ^ z_out;
   assign ks_valid   = ks_valid_q;
   assign regs_clear = regs_clear_q;
   assign done       = done_q;
   assign busy       = (state_q != S_IDLE);

   always_comb begin
      ks_valid_d = ks_valid_q;
      if ((state_q == S_GEN) && fire)
         ks_valid_d = 1'b1;
      else if (ks_valid_q && ks_ready)
         ks_valid_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         key_q        <= '0;
         frame_q      <= '0;
         regs_clear_q <= 1'b0;
         ks_valid_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         regs_clear_q <= 1'b0;
         done_q       <= 1'b0;
         ks_valid_q   <= ks_valid_d;
         unique case (state_q)
            S_IDLE: begin
               // done_q still high means the previous run ends this cycle
               if (start && !done_q) begin
                  key_q        <= key;
                  frame_q      <= frame;
                  regs_clear_q <= 1'b1;
                  cnt_q        <= '0;
                  state_q      <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               cnt_q   <= '0;
               state_q <= S_KEY;
            end
            S_KEY: begin
               key_q <= key_q >> 1;
               if (cnt_q == KEY_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_FRAME;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_FRAME: begin
               frame_q <= frame_q >> 1;
               if (cnt_q == FRAME_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_MIX;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_MIX: begin
               if (cnt_q == MIX_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_GEN;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_GEN: begin
               if (fire) begin
                  if (cnt_q == KS_LAST) begin
                     cnt_q   <= '0;
                     state_q <= S_DRAIN;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
            end
            S_DRAIN: begin
               if (!ks_valid_q) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_a5_1_controller.sv
// Bench: controller driving behavioural X/Y/Z registers, keystream
// compared against a stand-alone A5/1 reference computed from key/frame.
module tb_a5_1_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [63:0] key = '0;
   logic [21:0] frame = '0;
   logic        x_maj, y_maj, z_maj;
   logic        x_out, y_out, z_out;
   logic        regs_clear;
   logic        x_trigger, y_trigger, z_trigger;
   logic        shift_bit, ks_bit, ks_valid;
   logic        ks_ready = 1'b1;
   logic        busy, done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   a5_1_controller dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .key        (key),
      .frame      (frame),
      .x_maj      (x_maj),
      .y_maj      (y_maj),
      .z_maj      (z_maj),
      .x_out      (x_out),
      .y_out      (y_out),
      .z_out      (z_out),
      .regs_clear (regs_clear),
      .x_trigger  (x_trigger),
      .y_trigger  (y_trigger),
      .z_trigger  (z_trigger),
      .shift_bit  (shift_bit),
      .ks_bit     (ks_bit),
      .ks_valid   (ks_valid),
      .ks_ready   (ks_ready),
      .busy       (busy),
      .done       (done)
   );

   // Behavioural X/Y/Z registers stepped by the controller
   logic [18:0] rx;
   logic [21:0] ry;
   logic [22:0] rz;
   logic frc = 1'b0;
   logic fx = 1'b0, fy = 1'b0, fz = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset || regs_clear) begin
         rx <= '0;
         ry <= '0;
         rz <= '0;
      end else begin
         if (x_trigger)
            rx <= {rx[17:0], rx[13] ^ rx[16] ^ rx[17] ^ rx[18] ^ shift_bit};
         if (y_trigger)
            ry <= {ry[20:0], ry[20] ^ ry[21] ^ shift_bit};
         if (z_trigger)
            rz <= {rz[21:0], rz[7] ^ rz[20] ^ rz[21] ^ rz[22] ^ shift_bit};
      end
   end

   assign x_maj = frc ? fx : rx[8];
   assign y_maj = frc ? fy : ry[10];
   assign z_maj = frc ? fz : rz[10];
   assign x_out = rx[18];
   assign y_out = ry[21];
   assign z_out = rz[22];

   function automatic logic [227:0] ref_ks(input logic [63:0] k,
                                           input logic [21:0] f);
      logic [63:0] r1, r2, r3;
      logic [227:0] o;
      logic b, c1, c2, c3, maj;
      int votes;
      r1 = '0; r2 = '0; r3 = '0; o = '0;
      for (int i = 0; i < 414; i++) begin
         if (i < 64) b = k[i];
         else if (i < 86) b = f[i-64];
         else b = 1'b0;
         if (i < 86) begin
            c1 = 1'b1; c2 = 1'b1; c3 = 1'b1;
         end else begin
            votes = int'(r1[8]) + int'(r2[10]) + int'(r3[10]);
            maj = (votes >= 2);
            c1 = (r1[8] == maj);
            c2 = (r2[10] == maj);
            c3 = (r3[10] == maj);
         end
         if (c1) r1 = ((r1 << 1) | 64'(^(r1 & 64'h72000) ^ b)) & 64'h7FFFF;
         if (c2) r2 = ((r2 << 1) | 64'(^(r2 & 64'h300000) ^ b)) & 64'h3FFFFF;
         if (c3) r3 = ((r3 << 1) | 64'(^(r3 & 64'h700080) ^ b)) & 64'h7FFFFF;
         if (i >= 186) o[i-186] = r1[18] ^ r2[21] ^ r3[22];
      end
      return o;
   endfunction

   localparam int NC = 1200;
   logic       rc_a [NC];
   logic [2:0] tr_a [NC];
   logic       sb_a [NC];
   logic       v_a  [NC];
   logic       kb_a [NC];
   logic       busy_a [NC];
   int first_v, done_c, nhs;
   logic [227:0] got;
   bit tmo;

   // mode 0: ready high, 1: random ready, 2: ready low in cycles 250..259
   task automatic run(input logic [63:0] k, input logic [21:0] f,
                      input int mode, input int inj);
      @(posedge clk); #1;
      key = k; frame = f; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      first_v = -1; done_c = -1; nhs = 0; got = '0; tmo = 1'b0;
      for (int c = 0; c < NC; c++) begin
         if (mode == 0) ks_ready = 1'b1;
         else if (mode == 1) ks_ready = ($urandom_range(0, 3) != 0);
         else ks_ready = !(c >= 250 && c < 260);
         if (c == inj) begin
            start = 1'b1; key = ~k; frame = ~f;
         end else begin
            start = 1'b0;
         end
         #1;
         rc_a[c] = regs_clear;
         tr_a[c] = {x_trigger, y_trigger, z_trigger};
         sb_a[c] = shift_bit;
         v_a[c] = ks_valid;
         kb_a[c] = ks_bit;
         busy_a[c] = busy;
         if (ks_valid && first_v < 0) first_v = c;
         if (ks_valid && ks_ready) begin
            if (nhs < 228) got[nhs] = ks_bit;
            nhs++;
         end
         if (done) begin
            done_c = c;
            break;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      ks_ready = 1'b1;
      if (done_c < 0) tmo = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({busy, done, ks_valid, regs_clear, x_trigger, y_trigger,
           z_trigger, shift_bit} !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=00000000",
                  {busy, done, ks_valid, regs_clear, x_trigger,
                   y_trigger, z_trigger, shift_bit});
      end
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, ks_valid, done} !== 3'b000) begin
         errors++;
         $display("FAIL idle_after_reset got=%b exp=000", {busy, ks_valid, done});
      end
   endtask

   task automatic test_latency();
      int nrc, ntr, nsb;
      run(64'h0, 22'h0, 0, -1);
      nrc = 0; ntr = 0; nsb = 0;
      for (int c = 0; c <= done_c && c >= 0; c++) begin
         if (rc_a[c]) nrc++;
         if (sb_a[c]) nsb++;
         if (c <= 86 && tr_a[c] == 3'b111) ntr++;
      end
      checks++;
      if (tmo) begin
         errors++;
         $display("FAIL run_timeout got=no_done exp=done");
      end
      checks++;
      if (nrc != 1 || rc_a[0] !== 1'b1) begin
         errors++;
         $display("FAIL regs_clear_pulse got=%0d exp=1", nrc);
      end
      checks++;
      if (ntr != 86 || tr_a[0] !== 3'b000) begin
         errors++;
         $display("FAIL load_triggers got=%0d exp=86", ntr);
      end
      checks++;
      if (nsb != 0) begin
         errors++;
         $display("FAIL zero_shift_bits got=%0d exp=0", nsb);
      end
      checks++;
      if (first_v != 188) begin
         errors++;
         $display("FAIL first_valid got=%0d exp=188", first_v);
      end
      checks++;
      if (nhs != 228) begin
         errors++;
         $display("FAIL handshakes got=%0d exp=228", nhs);
      end
      checks++;
      if (done_c != 417) begin
         errors++;
         $display("FAIL done_cycle got=%0d exp=417", done_c);
      end
      checks++;
      if (busy_a[1] !== 1'b1) begin
         errors++;
         $display("FAIL busy_running got=%b exp=1", busy_a[1]);
      end
   endtask

   task automatic test_shift_bits();
      int n;
      run(64'h1, 22'h0, 0, -1);
      n = 0;
      for (int c = 0; c <= done_c && c >= 0; c++) if (sb_a[c]) n++;
      checks++;
      if (n != 1 || sb_a[1] !== 1'b1) begin
         errors++;
         $display("FAIL key_lsb_shift got=%0d/%b exp=1/1", n, sb_a[1]);
      end
      checks++;
      if (got !== ref_ks(64'h1, 22'h0)) begin
         errors++;
         $display("FAIL ks_key1 got=%h exp=%h", got, ref_ks(64'h1, 22'h0));
      end
      run(64'h0, 22'h200000, 0, -1);
      n = 0;
      for (int c = 0; c <= done_c && c >= 0; c++) if (sb_a[c]) n++;
      checks++;
      if (n != 1 || sb_a[86] !== 1'b1) begin
         errors++;
         $display("FAIL frame_msb_shift got=%0d/%b exp=1/1", n, sb_a[86]);
      end
   endtask

   task automatic test_majority();
      logic [2:0] pat [4];
      logic [2:0] exp [4];
      pat[0] = 3'b110; exp[0] = 3'b110;
      pat[1] = 3'b000; exp[1] = 3'b111;
      pat[2] = 3'b011; exp[2] = 3'b011;
      pat[3] = 3'b101; exp[3] = 3'b101;
      @(posedge clk); #1;
      key = {$urandom, $urandom}; frame = 22'($urandom); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      frc = 1'b1; {fx, fy, fz} = 3'b100;
      #1;
      checks++;
      if ({x_trigger, y_trigger, z_trigger} !== 3'b111) begin
         errors++;
         $display("FAIL key_ignores_maj got=%b exp=111",
                  {x_trigger, y_trigger, z_trigger});
      end
      frc = 1'b0;
      repeat (110) @(posedge clk);
      #1;
      frc = 1'b1;
      for (int i = 0; i < 4; i++) begin
         {fx, fy, fz} = pat[i];
         #1;
         checks++;
         if ({x_trigger, y_trigger, z_trigger} !== exp[i]) begin
            errors++;
            $display("FAIL mix_majority maj=%b got=%b exp=%b", pat[i],
                     {x_trigger, y_trigger, z_trigger}, exp[i]);
         end
      end
      frc = 1'b0;
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_golden();
      run(64'h1223456789ABCDEF, 22'h134, 0, -1);
      checks++;
      if (nhs != 228 || got !== ref_ks(64'h1223456789ABCDEF, 22'h134)) begin
         errors++;
         $display("FAIL golden_ks n=%0d got=%h exp=%h", nhs, got,
                  ref_ks(64'h1223456789ABCDEF, 22'h134));
      end
   endtask

   task automatic test_stall();
      logic [63:0] k;
      logic [21:0] f;
      int bad;
      k = {$urandom, $urandom}; f = 22'($urandom);
      run(k, f, 2, -1);
      bad = 0;
      for (int c = 250; c < 260; c++)
         if (v_a[c] !== 1'b1 || kb_a[c] !== kb_a[250] || tr_a[c] !== 3'b000)
            bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stall_hold got=%0d_bad_cycles exp=0", bad);
      end
      checks++;
      if (nhs != 228 || got !== ref_ks(k, f)) begin
         errors++;
         $display("FAIL stall_stream n=%0d got=%h exp=%h", nhs, got, ref_ks(k, f));
      end
      checks++;
      if (done_c != 427) begin
         errors++;
         $display("FAIL stall_done got=%0d exp=427", done_c);
      end
   endtask

   task automatic test_random_ready();
      logic [63:0] k;
      logic [21:0] f;
      for (int i = 0; i < 3; i++) begin
         k = {$urandom, $urandom}; f = 22'($urandom);
         run(k, f, 1, -1);
         checks++;
         if (tmo || nhs != 228 || got !== ref_ks(k, f)) begin
            errors++;
            $display("FAIL random_ready run=%0d n=%0d got=%h exp=%h",
                     i, nhs, got, ref_ks(k, f));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [63:0] k;
      logic [21:0] f;
      int at [2];
      at[0] = 120; at[1] = 300;
      k = {$urandom, $urandom}; f = 22'($urandom);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         key = k; frame = f; start = 1'b1; ks_ready = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         repeat (at[i]) @(posedge clk);
         #1;
         checks++;
         if (busy !== 1'b1 || (i == 1 && ks_valid !== 1'b1)) begin
            errors++;
            $display("FAIL pre_reset_state at=%0d got=%b%b exp=1%0d",
                     at[i], busy, ks_valid, i);
         end
         reset = 1'b1;
         #1;
         checks++;
         if ({busy, ks_valid, x_trigger, y_trigger, z_trigger,
              regs_clear, done, shift_bit} !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset at=%0d got=%b exp=00000000", at[i],
                     {busy, ks_valid, x_trigger, y_trigger, z_trigger,
                      regs_clear, done, shift_bit});
         end
         @(negedge clk); reset = 1'b0;
      end
      run(k, f, 0, -1);
      checks++;
      if (nhs != 228 || got !== ref_ks(k, f)) begin
         errors++;
         $display("FAIL after_reset_stream got=%h exp=%h", got, ref_ks(k, f));
      end
   endtask

   task automatic test_start_ignored();
      logic [63:0] k;
      logic [21:0] f;
      k = {$urandom, $urandom}; f = 22'($urandom);
      run(k, f, 0, 250);
      checks++;
      if (nhs != 228 || got !== ref_ks(k, f)) begin
         errors++;
         $display("FAIL start_in_gen got=%h exp=%h", got, ref_ks(k, f));
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || regs_clear !== 1'b0) begin
         errors++;
         $display("FAIL start_on_done got=%b%b exp=00", busy, regs_clear);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_shift_bits();
      test_majority();
      test_golden();
      test_stall();
      test_random_ready();
      test_reset_mid();
      test_start_ignored();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
